// File: rtl/io_bus_arbiter_pkg.sv
// io_arb_pkg: shared types, default parameter values and width helpers for the
// uio pin-bank arbiter.
//   arb_state_e     IDLE / OWN / TURN, 2-bit encoding
//   DEF_*           default parameter values used by the arbiter and rr_pick
//   ptr_w()         requester index width
//   hold_w()        hold counter width (MAX_HOLD=0 still gets one bit)
//   turn_w()        turnaround counter width
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_MAX_HOLD    = 8;
  localparam int DEF_TURN_CYCLES = 1;

  localparam logic [7:0] DEF_IDLE_OUT = 8'hFF;
  localparam logic [7:0] DEF_IDLE_OE  = 8'hFF;

  // Width of a requester index; never below one bit.
  function automatic int ptr_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // Width of the hold counter, $clog2(MAX_HOLD+1) with a one-bit floor.
  function automatic int hold_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

  // Width of the turnaround counter, $clog2(TURN_CYCLES+1) with a one-bit floor.
  function automatic int turn_w(input int turn_cycles);
    return (turn_cycles < 1) ? 1 : $clog2(turn_cycles + 1);
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: requester-side and pin-side signals of the uio arbiter.
//   req       requests, one per requester (level-sensitive)
//   req_data  packed per-requester output data, requester i at [i*DATA_W +: DATA_W]
//   req_oe    packed per-requester output enables, same packing
//   grant     one-hot owner, zero outside OWN
//   bus_out   registered value for uio_out
//   bus_oe    registered value for uio_oe
//   busy      high while a requester owns the bus or the bus is turning around
// Modports: master = requester side, slave = arbiter side.
interface io_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*DATA_W-1:0] req_oe;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         bus_out;
  logic [DATA_W-1:0]         bus_oe;
  logic                      busy;

  modport master (
    output req, req_data, req_oe,
    input  grant, bus_out, bus_oe, busy
  );

  modport slave (
    input  req, req_data, req_oe,
    output grant, bus_out, bus_oe, busy
  );

endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req       request vector
//   ptr       highest-priority index for this round
//   pick_oh   one-hot winner (zero when no request)
//   pick_idx  index of the winner (zero when no request)
//   any       at least one request is set
// The winner is the first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = ptr_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest hit is kept last.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    cand     = '0;
    any      = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_idx = cand;
      end else begin
        pick_idx = pick_idx;
      end
    end
    if (any) begin
      pick_oh = NUM_REQ'(1'b1) << pick_idx;
    end else begin
      pick_oh = '0;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the uio output pin bank between NUM_REQ requesters.
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    io_bus_arbiter_if.slave: req/req_data/req_oe in, grant/bus_out/bus_oe/busy out
// Round-robin grants with a bounded hold while others wait, a TURN gap with all
// enables released between owners, and the idle pattern when nobody owns the bus.
// Every output is a flop whose next value is derived from the next state.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int              NUM_REQ     = DEF_NUM_REQ,
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              MAX_HOLD    = DEF_MAX_HOLD,
  parameter int              TURN_CYCLES = DEF_TURN_CYCLES,
  parameter logic [DATA_W-1:0] IDLE_OUT  = DEF_IDLE_OUT,
  parameter logic [DATA_W-1:0] IDLE_OE   = DEF_IDLE_OE
) (
  input logic               clk,
  input logic               reset,
  io_bus_arbiter_if.slave   bus
);

  localparam int IDX_W      = ptr_w(NUM_REQ);
  localparam int CNT_HOLD_W = hold_w(MAX_HOLD);
  localparam int CNT_TURN_W = turn_w(TURN_CYCLES);

  // hold_cnt saturates at the value that triggers a contended release, so a
  // contender arriving after expiry takes the bus on its first waiting cycle.
  localparam logic [CNT_HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {CNT_HOLD_W{1'b1}} : CNT_HOLD_W'(MAX_HOLD - 1);
  localparam logic [CNT_TURN_W-1:0] TURN_LAST = CNT_TURN_W'(TURN_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [CNT_HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]      bus_out_q, bus_out_d;
  logic [DATA_W-1:0]      bus_oe_q, bus_oe_d;
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   owner_req;
  logic [DATA_W-1:0]      owner_data;
  logic [DATA_W-1:0]      owner_oe;
  logic                   others_waiting;
  logic                   hold_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Select the current owner's request, data and enables; non-owners never pass.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    owner_oe   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req  = bus.req[i];
        owner_data = bus.req_data[i*DATA_W +: DATA_W];
        owner_oe   = bus.req_oe[i*DATA_W +: DATA_W];
      end else begin
        owner_req  = owner_req;
        owner_data = owner_data;
        owner_oe   = owner_oe;
      end
    end
  end

  assign others_waiting = |(bus.req & ~grant_q);
  assign hold_expired   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT);

  // Next-state, pointer, counters and grant.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = OWN;
          owner_d    = pick_idx;
          grant_d    = pick_oh;
          hold_cnt_d = '0;
        end else begin
          grant_d    = '0;
        end
      end
      OWN: begin
        if (!owner_req || (hold_expired && others_waiting)) begin
          // Released owner gets lowest priority in the next arbitration.
          state_d    = TURN;
          ptr_d      = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
          grant_d    = '0;
          turn_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_HOLD_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      TURN: begin
        grant_d = '0;
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = IDLE;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + CNT_TURN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Pin values follow the state being entered; owner data only once already owning,
  // giving the one-cycle sample-to-pin latency.
  always_comb begin
    bus_out_d = IDLE_OUT;
    bus_oe_d  = IDLE_OE;
    case (state_d)
      OWN: begin
        if (state_q == OWN) begin
          bus_out_d = owner_data;
          bus_oe_d  = owner_oe;
        end else begin
          bus_out_d = IDLE_OUT;
          bus_oe_d  = IDLE_OE;
        end
      end
      TURN: begin
        bus_out_d = IDLE_OUT;
        bus_oe_d  = '0;
      end
      IDLE: begin
        bus_out_d = IDLE_OUT;
        bus_oe_d  = IDLE_OE;
      end
      default: begin
        bus_out_d = IDLE_OUT;
        bus_oe_d  = IDLE_OE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      grant_q    <= '0;
      bus_out_q  <= IDLE_OUT;
      bus_oe_q   <= IDLE_OE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      grant_q    <= grant_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.bus_out = bus_out_q;
  assign bus.bus_oe  = bus_oe_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed stimulus for io_bus_arbiter (4 requesters, 8-bit
// bank, MAX_HOLD=8, TURN_CYCLES=1). A cycle-level behavioural model of the
// ownership rules predicts grant/bus_out/bus_oe/busy every cycle; literal
// expectations at key points pin the model's timing.
module tb_io_bus_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int MAX_HOLD    = 8;
  localparam int TURN_CYCLES = 1;

  logic clk;
  logic reset;

  io_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus_if ();

  io_bus_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .MAX_HOLD    (MAX_HOLD),
    .TURN_CYCLES (TURN_CYCLES),
    .IDLE_OUT    (8'hFF),
    .IDLE_OE     (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: who owns the bus, for how many cycles, remaining release cycles.
  int         m_owner;
  int         m_held;
  int         m_release;
  int         m_ptr;
  logic       m_valid;
  logic [3:0] e_grant;
  logic [7:0] e_out;
  logic [7:0] e_oe;
  logic       e_busy;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle_outs();
    e_grant = 4'b0000;
    e_out   = 8'hFF;
    e_oe    = 8'hFF;
    e_busy  = 1'b0;
  endtask

  // Predict outputs after the coming clock edge from the inputs held now.
  task automatic model_step();
    logic [3:0] r;
    logic       others;
    r = bus_if.req;
    if (reset) begin
      m_owner   = -1;
      m_release = 0;
      m_ptr     = 0;
      m_held    = 0;
      set_idle_outs();
    end else if (m_owner >= 0) begin
      m_held++;
      others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
      if (!r[m_owner] || (MAX_HOLD > 0 && m_held >= MAX_HOLD && others)) begin
        m_ptr     = (m_owner + 1) % NUM_REQ;
        m_owner   = -1;
        m_release = TURN_CYCLES;
        e_grant   = 4'b0000;
        e_out     = 8'hFF;
        e_oe      = 8'h00;
        e_busy    = 1'b1;
      end else begin
        e_grant = 4'b0001 << m_owner;
        e_out   = bus_if.req_data[m_owner*8 +: 8];
        e_oe    = bus_if.req_oe[m_owner*8 +: 8];
        e_busy  = 1'b1;
      end
    end else if (m_release > 0) begin
      m_release--;
      if (m_release == 0) begin
        set_idle_outs();
      end else begin
        e_grant = 4'b0000;
        e_out   = 8'hFF;
        e_oe    = 8'h00;
        e_busy  = 1'b1;
      end
    end else if (r != 4'b0000) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
      end
      m_held  = 0;
      e_grant = 4'b0001 << m_owner;
      e_out   = 8'hFF;
      e_oe    = 8'hFF;
      e_busy  = 1'b1;
    end else begin
      set_idle_outs();
    end
  endtask

  // Compare process: on each falling edge check DUT against the model, then advance it.
  initial begin
    m_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("grant", bus_if.grant, e_grant);
        chk("bus_out", bus_if.bus_out, e_out);
        chk("bus_oe", bus_if.bus_oe, e_oe);
        chk("busy", bus_if.busy, e_busy);
        chk("grant_onehot0", $countones(bus_if.grant) <= 1, 1);
      end
      model_step();
      m_valid = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic [7:0] oe);
    bus_if.req_data[i*8 +: 8] = d;
    bus_if.req_oe[i*8 +: 8]   = oe;
  endtask

  task automatic chk_outs(input string name, input logic [3:0] g, input logic [7:0] o,
                          input logic [7:0] oe, input logic b);
    chk({name, "_grant"}, bus_if.grant, g);
    chk({name, "_out"}, bus_if.bus_out, o);
    chk({name, "_oe"}, bus_if.bus_oe, oe);
    chk({name, "_busy"}, bus_if.busy, b);
  endtask

  logic [3:0] rr_val [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                             4'b0100, 4'b0000, 4'b1000, 4'b0000};
  int         rr_len [8] = '{8, 2, 8, 2, 8, 2, 8, 2};
  logic [3:0] seg_val [$];
  int         seg_len [$];
  logic [3:0] cur_val;
  int         cur_len;
  int         good;
  int         bad;

  initial begin
    reset      = 1'b1;
    bus_if.req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 8'hA0 + 8'(i), 8'hF0 | 8'(i));

    // Reset held three cycles with all requests up.
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk_outs("rst", 4'b0000, 8'hFF, 8'hFF, 1'b0);
    end
    reset = 1'b0;
    step(1);
    chk_outs("rel", 4'b0001, 8'hFF, 8'hFF, 1'b1);
    step(1);
    chk_outs("rel_data", 4'b0001, 8'hA0, 8'hF0, 1'b1);
    bus_if.req = 4'b0000;
    step(1);
    chk_outs("rel_turn", 4'b0000, 8'hFF, 8'h00, 1'b1);
    step(1);
    chk_outs("rel_idle", 4'b0000, 8'hFF, 8'hFF, 1'b0);

    // Single owner.
    set_src(1, 8'hA5, 8'h0F);
    bus_if.req = 4'b0010;
    step(1);
    chk_outs("one_grant", 4'b0010, 8'hFF, 8'hFF, 1'b1);
    step(1);
    chk_outs("one_data", 4'b0010, 8'hA5, 8'h0F, 1'b1);
    bus_if.req = 4'b0000;
    step(1);
    chk_outs("one_turn", 4'b0000, 8'hFF, 8'h00, 1'b1);
    step(1);
    chk_outs("one_idle", 4'b0000, 8'hFF, 8'hFF, 1'b0);

    // Round-robin with everyone requesting, starting from ptr=0.
    reset = 1'b1;
    step(1);
    reset      = 1'b0;
    bus_if.req = 4'b1111;
    step(1);
    cur_val = bus_if.grant;
    cur_len = 1;
    for (int c = 1; c < 45; c++) begin
      step(1);
      if (bus_if.grant == cur_val) begin
        cur_len++;
      end else begin
        seg_val.push_back(cur_val);
        seg_len.push_back(cur_len);
        cur_val = bus_if.grant;
        cur_len = 1;
      end
    end
    chk("rr_segments", seg_val.size() >= 8, 1);
    for (int s = 0; s < 8; s++) begin
      if (s < seg_val.size()) begin
        chk($sformatf("rr_val%0d", s), seg_val[s], rr_val[s]);
        chk($sformatf("rr_len%0d", s), seg_len[s], rr_len[s]);
      end
    end
    chk("rr_fifth_owner", cur_val, 4'b0001);

    // Hold expiry with no contender: requester 2 alone.
    bus_if.req = 4'b0100;
    step(3);
    chk("solo_grant", bus_if.grant, 4'b0100);
    good = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (bus_if.grant == 4'b0100 && bus_if.busy && bus_if.bus_oe != 8'h00) good++;
    end
    chk("solo_cycles", good, 20);

    // Reset while requester 2 owns the bus.
    reset = 1'b1;
    step(1);
    chk_outs("rst_own", 4'b0000, 8'hFF, 8'hFF, 1'b0);
    reset      = 1'b0;
    bus_if.req = 4'b0101;
    step(1);
    chk("rst_own_next", bus_if.grant, 4'b0001);

    // Reset during TURN.
    bus_if.req = 4'b0100;
    step(1);
    chk_outs("turn_pre", 4'b0000, 8'hFF, 8'h00, 1'b1);
    reset = 1'b1;
    step(1);
    chk_outs("rst_turn", 4'b0000, 8'hFF, 8'hFF, 1'b0);
    reset      = 1'b0;
    bus_if.req = 4'b0101;
    step(1);
    chk("rst_turn_next", bus_if.grant, 4'b0001);

    // Late contender after the hold has expired: immediate release.
    bus_if.req = 4'b0001;
    step(12);
    chk("late_hold", bus_if.grant, 4'b0001);
    bus_if.req = 4'b0011;
    step(1);
    chk_outs("late_rel", 4'b0000, 8'hFF, 8'h00, 1'b1);

    // Contention isolation: non-owners drive 00 with all enables.
    set_src(0, 8'h00, 8'hFF);
    set_src(2, 8'h00, 8'hFF);
    set_src(3, 8'h00, 8'hFF);
    set_src(1, 8'h3C, 8'hC3);
    bus_if.req = 4'b0010;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (bus_if.bus_out == 8'h00 && bus_if.bus_oe == 8'hFF) bad++;
    end
    chk("iso_leak", bad, 0);
    chk_outs("iso_owner", 4'b0010, 8'h3C, 8'hC3, 1'b1);

    bus_if.req = 4'b0000;
    step(3);
    chk_outs("end_idle", 4'b0000, 8'hFF, 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
